// File: rtl/pump_cmd_decoder_if.sv
// Byte-stream input and decoded command outputs of the pump command decoder.
// The decoder takes the slave modport; whatever feeds it bytes takes the master modport.
interface pump_cmd_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [1:0] fragrance_select;
  logic [1:0] timer_select;
  logic       pump_on;
  logic       pump_off;
  logic       manual_on;
  logic       frame_ok;
  logic       cmd_error;
  logic [7:0] err_count;

  modport master (
    output rx_data, rx_valid,
    input  fragrance_select, timer_select, pump_on, pump_off,
    input  manual_on, frame_ok, cmd_error, err_count
  );

  modport slave (
    input  rx_data, rx_valid,
    output fragrance_select, timer_select, pump_on, pump_off,
    output manual_on, frame_ok, cmd_error, err_count
  );
endinterface

// File: rtl/pump_cmd_decoder.sv
// Decodes 4-byte frames (A5, CMD, ARG, CMD^ARG) into pump selects and one-cycle
// command pulses. Bad or stalled frames raise cmd_error and bump a saturating counter.
module pump_cmd_decoder #(
  parameter int CLOCK_FREQ = 1_000_000,
  parameter int TIMEOUT_MS = 10
) (
  input  logic       clk,
  input  logic       rst,
  pump_cmd_if.slave  bus
);

  localparam int GAP_LIMIT_INT = CLOCK_FREQ / 1000 * TIMEOUT_MS;
  localparam int GAP_W = $clog2(GAP_LIMIT_INT + 1);
  localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(GAP_LIMIT_INT);

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CMD_ON    = 8'h01;
  localparam logic [7:0] CMD_OFF   = 8'h02;
  localparam logic [7:0] CMD_MAN   = 8'h03;
  localparam logic [7:0] CMD_TIMER = 8'h04;

  typedef enum logic [1:0] {IDLE, GET_CMD, GET_ARG, GET_CHK} state_t;

  state_t           state_q, state_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [7:0]       arg_q, arg_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [1:0]       frag_q, frag_d;
  logic [1:0]       timer_q, timer_d;
  logic             pump_on_q, pump_on_d;
  logic             pump_off_q, pump_off_d;
  logic             manual_on_q, manual_on_d;
  logic             frame_ok_q, frame_ok_d;
  logic             cmd_error_q, cmd_error_d;
  logic [7:0]       err_q, err_d;

  logic             cmd_arg_valid;
  logic             frame_good;
  logic             err_event;

  // CMD/ARG legality depends only on the stored bytes; the checksum uses the live CHK byte.
  always_comb begin
    cmd_arg_valid = 1'b0;
    case (cmd_q)
      CMD_ON, CMD_MAN, CMD_TIMER: cmd_arg_valid = (arg_q <= 8'd2);
      CMD_OFF:                    cmd_arg_valid = (arg_q == 8'h00);
      default:                    cmd_arg_valid = 1'b0;
    endcase
    frame_good = cmd_arg_valid && (bus.rx_data == (cmd_q ^ arg_q));
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    arg_d       = arg_q;
    gap_d       = gap_q;
    frag_d      = frag_q;
    timer_d     = timer_q;
    pump_on_d   = 1'b0;
    pump_off_d  = 1'b0;
    manual_on_d = 1'b0;
    frame_ok_d  = 1'b0;
    err_event   = 1'b0;

    if (bus.rx_valid) begin
      gap_d = '0;
      case (state_q)
        IDLE: begin
          if (bus.rx_data == SYNC_BYTE) state_d = GET_CMD;
        end
        GET_CMD: begin
          cmd_d   = bus.rx_data;
          state_d = GET_ARG;
        end
        GET_ARG: begin
          arg_d   = bus.rx_data;
          state_d = GET_CHK;
        end
        GET_CHK: begin
          state_d = IDLE;
          if (frame_good) begin
            frame_ok_d = 1'b1;
            case (cmd_q)
              CMD_ON: begin
                frag_d    = arg_q[1:0];
                pump_on_d = 1'b1;
              end
              CMD_OFF: pump_off_d = 1'b1;
              CMD_MAN: begin
                frag_d      = arg_q[1:0];
                manual_on_d = 1'b1;
              end
              CMD_TIMER: timer_d = arg_q[1:0];
              default: ;
            endcase
          end else begin
            err_event = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      // A byte arriving on the timeout cycle wins because this branch is skipped.
      if (gap_q == GAP_LIMIT) begin
        state_d   = IDLE;
        gap_d     = '0;
        err_event = 1'b1;
      end else begin
        gap_d = gap_q + GAP_W'(1);
      end
    end

    cmd_error_d = err_event;
    err_d       = (err_event && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      arg_q       <= '0;
      gap_q       <= '0;
      frag_q      <= '0;
      timer_q     <= '0;
      pump_on_q   <= 1'b0;
      pump_off_q  <= 1'b0;
      manual_on_q <= 1'b0;
      frame_ok_q  <= 1'b0;
      cmd_error_q <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      arg_q       <= arg_d;
      gap_q       <= gap_d;
      frag_q      <= frag_d;
      timer_q     <= timer_d;
      pump_on_q   <= pump_on_d;
      pump_off_q  <= pump_off_d;
      manual_on_q <= manual_on_d;
      frame_ok_q  <= frame_ok_d;
      cmd_error_q <= cmd_error_d;
      err_q       <= err_d;
    end
  end

  assign bus.fragrance_select = frag_q;
  assign bus.timer_select     = timer_q;
  assign bus.pump_on          = pump_on_q;
  assign bus.pump_off         = pump_off_q;
  assign bus.manual_on        = manual_on_q;
  assign bus.frame_ok         = frame_ok_q;
  assign bus.cmd_error        = cmd_error_q;
  assign bus.err_count        = err_q;

endmodule

// File: tb/tb_pump_cmd_decoder.sv
// Directed bench for pump_cmd_decoder: each task drives one scenario and checks
// the outputs one cycle after the CHK byte against hand-computed values.
module tb_pump_cmd_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total = 0;

  pump_cmd_if bus ();

  pump_cmd_decoder #(.CLOCK_FREQ(1_000_000), .TIMEOUT_MS(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b0, b1, b2, b3);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
    $display("frame %h %h %h %h -> fs=%0d ts=%0d on=%0b off=%0b man=%0b ok=%0b err=%0b cnt=%0d",
             b0, b1, b2, b3, bus.fragrance_select, bus.timer_select, bus.pump_on,
             bus.pump_off, bus.manual_on, bus.frame_ok, bus.cmd_error, bus.err_count);
  endtask

  task automatic test_reset;
    bus.rx_data  = 8'hA5;
    bus.rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (bus.fragrance_select !== 2'd0) $display("FAIL rst_fs: got %0d want 0", bus.fragrance_select); else passed++;
    total++; if (bus.timer_select !== 2'd0) $display("FAIL rst_ts: got %0d want 0", bus.timer_select); else passed++;
    total++; if ({bus.pump_on, bus.pump_off, bus.manual_on, bus.frame_ok, bus.cmd_error} !== 5'b0)
      $display("FAIL rst_pulses: got %b want 00000", {bus.pump_on, bus.pump_off, bus.manual_on, bus.frame_ok, bus.cmd_error}); else passed++;
    total++; if (bus.err_count !== 8'd0) $display("FAIL rst_errcnt: got %0d want 0", bus.err_count); else passed++;
    bus.rx_valid = 1'b0;
    rst = 1'b0;
    // A5 seen during reset must not have started a frame: 01 00 01 is then ignored
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h01);
    total++; if ({bus.pump_on, bus.frame_ok, bus.cmd_error} !== 3'b0)
      $display("FAIL rst_ignore_valid: got %b want 000", {bus.pump_on, bus.frame_ok, bus.cmd_error}); else passed++;
  endtask

  task automatic test_on;
    send_frame(8'hA5, 8'h01, 8'h02, 8'h03);
    total++; if (bus.fragrance_select !== 2'd2) $display("FAIL on_fs: got %0d want 2", bus.fragrance_select); else passed++;
    total++; if (bus.pump_on !== 1'b1) $display("FAIL on_pulse: got %0b want 1", bus.pump_on); else passed++;
    total++; if (bus.frame_ok !== 1'b1) $display("FAIL on_frame_ok: got %0b want 1", bus.frame_ok); else passed++;
    total++; if ({bus.pump_off, bus.manual_on, bus.cmd_error} !== 3'b0)
      $display("FAIL on_others: got %b want 000", {bus.pump_off, bus.manual_on, bus.cmd_error}); else passed++;
    @(negedge clk);
    total++; if ({bus.pump_on, bus.frame_ok} !== 2'b0) $display("FAIL on_width: got %b want 00", {bus.pump_on, bus.frame_ok}); else passed++;
    total++; if (bus.fragrance_select !== 2'd2) $display("FAIL on_fs_hold: got %0d want 2", bus.fragrance_select); else passed++;
  endtask

  task automatic test_timer_manual;
    send_frame(8'hA5, 8'h04, 8'h01, 8'h05);
    total++; if (bus.timer_select !== 2'd1) $display("FAIL timer_ts: got %0d want 1", bus.timer_select); else passed++;
    total++; if ({bus.pump_on, bus.pump_off, bus.manual_on} !== 3'b0)
      $display("FAIL timer_nopulse: got %b want 000", {bus.pump_on, bus.pump_off, bus.manual_on}); else passed++;
    total++; if (bus.frame_ok !== 1'b1) $display("FAIL timer_frame_ok: got %0b want 1", bus.frame_ok); else passed++;
    total++; if (bus.fragrance_select !== 2'd2) $display("FAIL timer_fs_hold: got %0d want 2", bus.fragrance_select); else passed++;
    send_frame(8'hA5, 8'h03, 8'h00, 8'h03);
    total++; if (bus.manual_on !== 1'b1) $display("FAIL man_pulse: got %0b want 1", bus.manual_on); else passed++;
    total++; if (bus.fragrance_select !== 2'd0) $display("FAIL man_fs: got %0d want 0", bus.fragrance_select); else passed++;
    total++; if ({bus.pump_on, bus.pump_off} !== 2'b0) $display("FAIL man_onehot: got %b want 00", {bus.pump_on, bus.pump_off}); else passed++;
    @(negedge clk);
    total++; if (bus.manual_on !== 1'b0) $display("FAIL man_width: got %0b want 0", bus.manual_on); else passed++;
    total++; if (bus.timer_select !== 2'd1) $display("FAIL man_ts_hold: got %0d want 1", bus.timer_select); else passed++;
  endtask

  task automatic test_bad_chk;
    send_frame(8'hA5, 8'h01, 8'h01, 8'h07);
    total++; if (bus.cmd_error !== 1'b1) $display("FAIL badchk_err: got %0b want 1", bus.cmd_error); else passed++;
    total++; if (bus.err_count !== 8'd1) $display("FAIL badchk_cnt: got %0d want 1", bus.err_count); else passed++;
    total++; if ({bus.pump_on, bus.pump_off, bus.manual_on, bus.frame_ok} !== 4'b0)
      $display("FAIL badchk_nopulse: got %b want 0000", {bus.pump_on, bus.pump_off, bus.manual_on, bus.frame_ok}); else passed++;
    total++; if ({bus.fragrance_select, bus.timer_select} !== 4'b00_01)
      $display("FAIL badchk_selects: got %b want 0001", {bus.fragrance_select, bus.timer_select}); else passed++;
    @(negedge clk);
    total++; if (bus.cmd_error !== 1'b0) $display("FAIL badchk_width: got %0b want 0", bus.cmd_error); else passed++;
  endtask

  task automatic test_timeout;
    int got;
    got = -1;
    send_byte(8'hA5);
    send_byte(8'h01);
    for (int n = 1; n <= 10100; n++) begin
      @(negedge clk);
      if (bus.cmd_error === 1'b1) begin
        got = n;
        break;
      end
    end
    total++; if (got < 10000 || got > 10002) $display("FAIL timeout_delay: got %0d want 10000..10002", got); else passed++;
    total++; if (bus.err_count !== 8'd2) $display("FAIL timeout_cnt: got %0d want 2", bus.err_count); else passed++;
    @(negedge clk);
    total++; if (bus.cmd_error !== 1'b0) $display("FAIL timeout_once: got %0b want 0", bus.cmd_error); else passed++;
    send_frame(8'hA5, 8'h02, 8'h00, 8'h02);
    total++; if (bus.pump_off !== 1'b1) $display("FAIL off_pulse: got %0b want 1", bus.pump_off); else passed++;
    total++; if (bus.fragrance_select !== 2'd0) $display("FAIL off_fs_hold: got %0d want 0", bus.fragrance_select); else passed++;
    total++; if (bus.frame_ok !== 1'b1) $display("FAIL off_frame_ok: got %0b want 1", bus.frame_ok); else passed++;
  endtask

  task automatic test_unknown_and_saturate;
    int err_seen;
    err_seen = 0;
    send_byte(8'h00);
    if (bus.cmd_error === 1'b1) err_seen++;
    send_byte(8'hFF);
    if (bus.cmd_error === 1'b1) err_seen++;
    total++; if (err_seen != 0) $display("FAIL junk_ignored: got %0d errors want 0", err_seen); else passed++;
    send_frame(8'hA5, 8'h05, 8'h00, 8'h05);
    total++; if (bus.cmd_error !== 1'b1) $display("FAIL unknown_err: got %0b want 1", bus.cmd_error); else passed++;
    total++; if (bus.err_count !== 8'd3) $display("FAIL unknown_cnt: got %0d want 3", bus.err_count); else passed++;
    for (int k = 0; k < 256; k++) begin
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01); send_byte(8'h07);
    end
    $display("frame a5 01 01 07 x256 -> err=%0b cnt=%0d", bus.cmd_error, bus.err_count);
    total++; if (bus.err_count !== 8'd255) $display("FAIL sat_cnt: got %0d want 255", bus.err_count); else passed++;
    total++; if (bus.cmd_error !== 1'b1) $display("FAIL sat_err_pulse: got %0b want 1", bus.cmd_error); else passed++;
  endtask

  task automatic test_reset_midframe;
    send_byte(8'hA5);
    send_byte(8'h01);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if ({bus.fragrance_select, bus.timer_select, bus.err_count} !== 12'd0)
      $display("FAIL midrst_regs: got %h want 000", {bus.fragrance_select, bus.timer_select, bus.err_count}); else passed++;
    @(negedge clk);
    rst = 1'b0;
    send_byte(8'h02);
    total++; if ({bus.pump_off, bus.frame_ok, bus.cmd_error} !== 3'b0)
      $display("FAIL midrst_ignore: got %b want 000", {bus.pump_off, bus.frame_ok, bus.cmd_error}); else passed++;
    send_frame(8'hA5, 8'h01, 8'h01, 8'h00);
    total++; if ({bus.pump_on, bus.cmd_error} !== 2'b10) $display("FAIL midrst_next: got %b want 10", {bus.pump_on, bus.cmd_error}); else passed++;
    total++; if (bus.fragrance_select !== 2'd1) $display("FAIL midrst_fs: got %0d want 1", bus.fragrance_select); else passed++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] stream [8];
    // A5 as ARG is data, so the frame is rejected for an out-of-range ARG
    send_frame(8'hA5, 8'h01, 8'hA5, 8'hA4);
    total++; if ({bus.cmd_error, bus.pump_on} !== 2'b10) $display("FAIL a5data: got %b want 10", {bus.cmd_error, bus.pump_on}); else passed++;
    total++; if (bus.err_count !== 8'd1) $display("FAIL a5data_cnt: got %0d want 1", bus.err_count); else passed++;
    stream = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'hA5, 8'h03, 8'h02, 8'h01};
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i == 4) begin
        total++; if ({bus.pump_on, bus.frame_ok, bus.fragrance_select} !== 4'b1100)
          $display("FAIL b2b_first: got %b want 1100", {bus.pump_on, bus.frame_ok, bus.fragrance_select}); else passed++;
      end
      if (i < 8) begin
        bus.rx_data  = stream[i];
        bus.rx_valid = 1'b1;
      end else begin
        bus.rx_valid = 1'b0;
        total++; if ({bus.manual_on, bus.pump_on, bus.cmd_error, bus.fragrance_select} !== 5'b10010)
          $display("FAIL b2b_second: got %b want 10010", {bus.manual_on, bus.pump_on, bus.cmd_error, bus.fragrance_select}); else passed++;
      end
    end
    $display("frame a5 01 00 01 + a5 03 02 01 back-to-back -> fs=%0d man=%0b", bus.fragrance_select, bus.manual_on);
  endtask

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    test_reset;
    test_on;
    test_timer_manual;
    test_bad_chk;
    test_timeout;
    test_unknown_and_saturate;
    test_reset_midframe;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pump_cmd_decoder.md
PUMP_CMD_DECODER -- requirements
Module: pump_cmd_decoder

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 1_000_000, meaning clk frequency in Hz.
REQ-002 SHALL have parameter TIMEOUT_MS, default 10, meaning the maximum inter-byte gap inside a frame, in milliseconds.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port rx_data, input, 8 bits: received byte from the UART receiver.
REQ-006 SHALL have port rx_valid, input, 1 bit: one-cycle strobe; rx_data is valid in that cycle.
REQ-007 SHALL have port fragrance_select, output, 2 bits: registered pump index, held between commands.
REQ-008 SHALL have port timer_select, output, 2 bits: registered period code, held between commands.
REQ-009 SHALL have port pump_on, output, 1 bit: one-cycle start pulse.
REQ-010 SHALL have port pump_off, output, 1 bit: one-cycle stop-all pulse.
REQ-011 SHALL have port manual_on, output, 1 bit: one-cycle forced-pulse strobe.
REQ-012 SHALL have port frame_ok, output, 1 bit: one-cycle pulse marking a valid frame.
REQ-013 SHALL have port cmd_error, output, 1 bit: one-cycle pulse marking a rejected frame.
REQ-014 SHALL have port err_count, output, 8 bits: count of rejected frames, saturating at 255.

Function
REQ-015 SHALL decode a 4-byte frame in this order: SYNC=0xA5, CMD, ARG, CHK, where CHK = CMD XOR ARG.
REQ-016 SHALL accept these CMD codes: 0x01 ON (ARG 0..2), 0x02 OFF (ARG = 0x00), 0x03 MANUAL (ARG 0..2), 0x04 SET_TIMER (ARG 0..2).
REQ-017 SHALL implement the states IDLE, GET_CMD, GET_ARG, GET_CHK, and change state only on cycles where rx_valid=1 or a timeout occurs.
REQ-018 SHALL, in IDLE, advance to GET_CMD on byte 0xA5 and silently ignore every other byte, with no error.
REQ-019 SHALL, in GET_CMD and GET_ARG, store the byte and advance; CMD and ARG are validated only at CHK.
REQ-020 SHALL, on the CHK byte, always return to IDLE, and either issue the command or reject the frame.
REQ-021 SHALL reject the frame when CHK mismatches, CMD is unknown, or ARG is out of range.
REQ-022 SHALL reject with: cmd_error=1 for exactly one cycle, err_count += 1 unless already 255, no command pulse, and fragrance_select/timer_select unchanged.
REQ-023 SHALL issue a valid frame with 1-cycle latency: CHK accepted in cycle N gives outputs in cycle N+1.
REQ-024 SHALL, for ON, in cycle N+1 set fragrance_select=ARG[1:0] and drive pump_on=1 in that same cycle.
REQ-025 SHALL, for MANUAL, in cycle N+1 set fragrance_select=ARG[1:0] and drive manual_on=1 in that same cycle.
REQ-026 SHALL, for OFF, drive pump_off=1 in cycle N+1, with fragrance_select unchanged.
REQ-027 SHALL, for SET_TIMER, set timer_select=ARG[1:0] in cycle N+1 with no command pulse.
REQ-028 SHALL drive frame_ok=1 in cycle N+1 for every issued frame.
REQ-029 SHALL never assert more than one of pump_on, pump_off, manual_on in the same cycle, and each SHALL be exactly one cycle wide.
REQ-030 SHALL run a gap counter of width ceil(log2(CLOCK_FREQ/1000*TIMEOUT_MS + 1)) bits, which clears on every rx_valid and counts while the state is not IDLE.
REQ-031 SHALL, when the gap counter reaches CLOCK_FREQ/1000*TIMEOUT_MS (10000 with defaults), go to IDLE with cmd_error=1 for one cycle and err_count += 1 (saturating).
REQ-032 SHALL give rx_valid priority over a timeout in the same cycle: the byte is processed and the counter clears.
REQ-033 SHALL, when byte 0xA5 arrives in GET_CMD, GET_ARG or GET_CHK, treat it as an ordinary data byte, not a resync.
REQ-034 SHALL, when rx_valid arrives in cycle N+1 (while a command is issuing), accept it normally in IDLE.

Reset
REQ-035 SHALL, while rst=1, immediately force: state IDLE, fragrance_select=0, timer_select=0, pump_on/pump_off/manual_on/frame_ok/cmd_error=0, err_count=0, gap counter=0.
REQ-036 SHALL discard a partially received frame when rst asserts mid-frame, issuing no pulse and no error.
REQ-037 SHALL ignore rx_valid while rst=1.

Verification
REQ-038 SHALL cover: frame A5 01 02 03 -> one cycle after CHK, fragrance_select=2, pump_on=1 for 1 cycle, frame_ok=1.
REQ-039 SHALL cover: A5 04 01 05, then A5 03 00 03 -> timer_select=1 with no pulse, then manual_on=1 for 1 cycle with fragrance_select=0.
REQ-040 SHALL cover: A5 01 01 07 (bad CHK) -> cmd_error=1 for 1 cycle, err_count=1, no pulse, selects unchanged.
REQ-041 SHALL cover: A5 01 then a 10000-cycle gap -> cmd_error=1 once, state IDLE; next frame A5 02 00 02 -> pump_off=1.
REQ-042 SHALL cover: bytes 00 FF, then A5 05 00 05 -> the 00 and FF bytes are ignored, the unknown CMD gives cmd_error; then 256 bad frames -> err_count holds 255.
REQ-043 SHALL cover: rst pulsed after A5 01 -> all outputs 0; following byte 02 is ignored in IDLE.
